// File: rtl/c4_tx.sv
// c4_tx -- buffered serial frame transmitter.
//
// Each accepted word goes out as a frame: a start bit (0), WIDTH data bits
// MSB first, an optional even-parity bit, and a stop bit (1). A one-word
// holding buffer lets the source load the next word while the current one
// is shifting, so consecutive frames follow each other with no idle gap.
// All state changes on the falling edge of n_clk.
//
// Parameters:
//   WIDTH      data bits per frame
//   PARITY_EN  1 = append an even-parity bit, 0 = no parity bit
//
// Ports:
//   n_clk  in   clock, falling-edge active
//   rst    in   asynchronous reset, active low
//   valid  in   din holds a word to send
//   din    in   parallel data word
//   ready  out  holding buffer empty; the word is taken on an edge with valid & ready
//   sdo    out  serial data, idle high
//   m      out  frame qualifier, high from the start bit through the stop bit
//   busy   out  FSM is not in IDLE
//   done   out  one-cycle pulse that coincides with the stop bit
module c4_tx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             n_clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sdo,
  output logic             m,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] buf_data;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic             accept, reload;
  logic             sdo_nxt, m_nxt, done_nxt;

  // The serial outputs are registered from the current state, so a frame
  // appears on sdo one cycle after the FSM enters START.
  always_comb begin
    accept    = valid & ready;
    reload    = ~ready & ((state == IDLE) || (state == STOP));
    state_nxt = state;
    cnt_nxt   = cnt;
    sdo_nxt   = 1'b1;
    m_nxt     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (reload) state_nxt = START;
      end
      START: begin
        sdo_nxt   = 1'b0;
        m_nxt     = 1'b1;
        cnt_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: begin
        sdo_nxt = shreg[WIDTH-1];
        m_nxt   = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (PARITY_EN != 0) ? PAR : STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PAR: begin
        sdo_nxt   = par;
        m_nxt     = 1'b1;
        state_nxt = STOP;
      end
      STOP: begin
        sdo_nxt   = 1'b1;
        m_nxt     = 1'b1;
        done_nxt  = 1'b1;
        // A waiting word starts immediately so back-to-back frames touch.
        state_nxt = reload ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and registered outputs
  always_ff @(negedge n_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      sdo   <= 1'b1;
      m     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // accept needs an empty buffer and reload a full one, so they never coincide
      if (accept)      ready <= 1'b0;
      else if (reload) ready <= 1'b1;
      sdo   <= sdo_nxt;
      m     <= m_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= done_nxt;
    end
  end

  // Datapath: holding buffer, shift register and parity of the loaded word
  always_ff @(negedge n_clk) begin
    if (accept) buf_data <= din;
    if (reload) begin
      shreg <= buf_data;
      par   <= ^buf_data;
    end else if (state == DATA) begin
      shreg <= shreg << 1;
    end
  end

endmodule

// File: tb/tb_c4_tx.sv
// Bench for c4_tx: scoreboard of expected frame bits per accepted word,
// a monitor popping them whenever m is high, directed frame tests and
// randomized traffic, plus a second instance without parity.
module tb_c4_tx;

  localparam int W = 8;

  logic         n_clk = 1'b1;
  logic         rst   = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] din   = '0;
  logic         ready, sdo, m, busy, done;

  logic         valid2 = 1'b0;
  logic [W-1:0] din2   = '0;
  logic         ready2, sdo2, m2, busy2, done2;

  c4_tx #(.WIDTH(W), .PARITY_EN(1)) dut (
    .n_clk(n_clk), .rst(rst), .valid(valid), .din(din),
    .ready(ready), .sdo(sdo), .m(m), .busy(busy), .done(done)
  );

  c4_tx #(.WIDTH(W), .PARITY_EN(0)) dut_np (
    .n_clk(n_clk), .rst(rst), .valid(valid2), .din(din2),
    .ready(ready2), .sdo(sdo2), .m(m2), .busy(busy2), .done(done2)
  );

  always #5 n_clk = ~n_clk;

  typedef struct packed {
    logic sdo;
    logic done;
  } exp_t;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t q[$];
  int   runs[$];
  int   starts[$];
  int   cyc = 0;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected line bits for one frame: start, data MSB first, even parity, stop.
  function automatic void push_frame(input logic [W-1:0] w);
    q.push_back(exp_t'{sdo: 1'b0, done: 1'b0});
    for (int i = W - 1; i >= 0; i--) q.push_back(exp_t'{sdo: w[i], done: 1'b0});
    q.push_back(exp_t'{sdo: ^w, done: 1'b0});
    q.push_back(exp_t'{sdo: 1'b1, done: 1'b1});
  endfunction

  initial forever begin
    @(negedge n_clk);
    cyc++;
  end

  // Monitor: samples on the rising edge, halfway between active edges.
  initial begin
    int   run_len;
    logic m_prev;
    logic pend_busy;
    exp_t e;
    run_len = 0; m_prev = 1'b0; pend_busy = 1'b0;
    forever begin
      @(posedge n_clk);
      if (rst) begin
        if (m) begin
          if (!m_prev) starts.push_back(cyc);
          run_len++;
          if (q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_frame_bit: m=1 with no word pending, sdo=%0b", sdo);
          end else begin
            e = q.pop_front();
            check("sdo_bit", sdo, e.sdo);
            check("done_bit", done, e.done);
          end
        end else begin
          if (m_prev) runs.push_back(run_len);
          run_len = 0;
          check("inv_m0_sdo1", sdo, 1);
        end
        if (done) begin
          check("inv_done_sdo1", sdo, 1);
          check("inv_done_m1", m, 1);
        end
        if (pend_busy) check("inv_ready0_busy", busy, 1);
        pend_busy = !ready && !busy;
        m_prev = m;
      end else begin
        run_len = 0; m_prev = 1'b0; pend_busy = 1'b0;
      end
    end
  end

  // Offer a word and hold it until the DUT takes it (ready high before the edge).
  task automatic send(input logic [W-1:0] w, output int acc_cyc);
    logic can;
    acc_cyc = -1;
    @(posedge n_clk);
    valid = 1'b1;
    din   = w;
    for (int t = 0; t < 200; t++) begin
      can = ready;
      @(negedge n_clk);
      if (can) begin
        #1;
        acc_cyc = cyc;
        push_frame(w);
        valid = 1'b0;
        din   = W'($urandom);
        return;
      end
      @(posedge n_clk);
    end
    valid = 1'b0;
    compared++; mismatched++;
    $display("FAIL accept_timeout: word %02h never accepted, ready=%0b", w, ready);
  endtask

  task automatic drain();
    for (int t = 0; t < 600; t++) begin
      @(posedge n_clk);
      #1;
      if (q.size() == 0 && !m && ready) return;
    end
    compared++; mismatched++;
    $display("FAIL drain_timeout: %0d expected bits still pending, m=%0b", q.size(), m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, acc2, gap, bad, n;
    logic can;
    logic [W-1:0] w;
    logic [15:0] bits, dn;

    // Reset values
    #1 rst = 1'b0;
    #3;
    check("rst_sdo", sdo, 1);     check("rst_m", m, 0);
    check("rst_ready", ready, 1); check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_np_sdo", sdo2, 1); check("rst_np_m", m2, 0);
    check("rst_np_ready", ready2, 1);

    // First accept on the first falling edge after release, single A5 frame
    valid = 1'b1;
    din   = 8'hA5;
    repeat (2) @(posedge n_clk);
    rst = 1'b1;
    runs.delete(); starts.delete();
    @(negedge n_clk);
    #1;
    check("first_accept_ready", ready, 0);
    acc = cyc;
    push_frame(8'hA5);
    valid = 1'b0;
    din   = 8'h00;
    drain();
    check("a5_frames", runs.size(), 1);
    if (runs.size() > 0) check("a5_m_len", runs[0], 11);
    if (starts.size() > 0) check("a5_latency", starts[0] - acc, 2);

    // Back-to-back 3C then FF
    runs.delete();
    send(8'h3C, acc);
    send(8'hFF, acc2);
    drain();
    check("b2b_runs", runs.size(), 1);
    if (runs.size() > 0) check("b2b_m_len", runs[0], 22);

    // 81 held while the buffer is full: taken once only
    runs.delete();
    send(8'hA5, acc);
    send(8'h3C, acc);
    send(8'h81, acc2);
    check("hold_81_accept_cycle", acc2 - acc, 11);
    drain();
    check("hold_runs", runs.size(), 1);
    if (runs.size() > 0) check("hold_m_len", runs[0], 33);

    // Reset during the 4th data bit
    send(8'hA5, acc);
    for (int t = 0; t < 20 && !m; t++) begin
      @(posedge n_clk);
      #1;
    end
    check("abort_frame_started", m, 1);
    repeat (4) @(negedge n_clk);
    #2 rst = 1'b0;
    #1;
    check("abort_sdo", sdo, 1);     check("abort_m", m, 0);
    check("abort_ready", ready, 1); check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    q.delete(); runs.delete(); starts.delete();
    @(negedge n_clk);
    @(negedge n_clk);
    @(posedge n_clk);
    rst = 1'b1;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge n_clk);
      #1;
      if (m || !sdo || !ready || busy) bad++;
    end
    check("post_reset_quiet_cycles", bad, 0);

    // Randomized traffic with random gaps, din scrambled after each accept
    for (int i = 0; i < 30; i++) begin
      w   = W'($urandom);
      gap = $urandom_range(0, 12);
      repeat (gap) @(posedge n_clk);
      send(w, acc);
    end
    drain();

    // No-parity instance, word 01
    @(posedge n_clk);
    valid2 = 1'b1;
    din2   = 8'h01;
    can    = ready2;
    @(negedge n_clk);
    #1;
    valid2 = 1'b0;
    din2   = 8'hFF;
    check("np_accept", int'(can && !ready2), 1);
    for (int t = 0; t < 20 && !m2; t++) @(posedge n_clk);
    n = 0; bits = '0; dn = '0;
    while (m2 && n < 16) begin
      bits[n] = sdo2;
      dn[n]   = done2;
      n++;
      @(posedge n_clk);
    end
    check("np_frame_len", n, 10);
    w = 8'h01;
    for (int i = 0; i < 10; i++)
      check($sformatf("np_bit%0d", i), bits[i],
            (i == 0) ? 0 : (i <= W) ? int'(w[W - i]) : 1);
    check("np_done_last", dn[9], 1);
    check("np_done_count", $countones(dn), 1);

    check("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
